// File: rtl/vfma_issue_sequencer_if.sv
// Issue/write-back bundle between the two vector issue slots and the FMA issue sequencer.
// master = requester/consumer side, slave = sequencer side.
interface vfma_issue_sequencer_if #(
  parameter int unsigned TAG_W = 4
);
  logic [1:0]         req_valid;
  logic [3:0]         req_lmul;
  logic [2*TAG_W-1:0] req_tag;
  logic [1:0]         req_ready;
  logic               fma_issue;
  logic [2:0]         fma_group_idx;
  logic               fma_req_id;
  logic               wb_valid;
  logic               wb_req_id;
  logic [2:0]         wb_group_idx;
  logic [TAG_W-1:0]   wb_tag;
  logic               wb_last;
  logic               busy;

  modport master (
    output req_valid, req_lmul, req_tag,
    input  req_ready, fma_issue, fma_group_idx, fma_req_id,
    input  wb_valid, wb_req_id, wb_group_idx, wb_tag, wb_last, busy
  );

  modport slave (
    input  req_valid, req_lmul, req_tag,
    output req_ready, fma_issue, fma_group_idx, fma_req_id,
    output wb_valid, wb_req_id, wb_group_idx, wb_tag, wb_last, busy
  );
endinterface

// File: rtl/vfma_issue_sequencer.sv
// Round-robin issue sequencer for the vector FMA unit: expands each accepted
// instruction into LMUL group micro-ops and tracks them through the fixed-latency pipe.
module vfma_issue_sequencer #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  vfma_issue_sequencer_if.slave bus
);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e           state_q, state_d;
  logic             rr_q;
  logic             id_q;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       idx_q;
  logic [2:0]       last_idx_q;

  logic [1:0]       grant;
  logic             accept;
  logic             winner;
  logic [1:0]       sel_lmul;
  logic [TAG_W-1:0] sel_tag;
  logic             last_issue;

  // Micro-op in-flight tracker, stage LATENCY-1 is the write-back stage.
  logic [LATENCY-1:0] sr_valid_q;
  logic               sr_id_q   [LATENCY];
  logic [2:0]         sr_idx_q  [LATENCY];
  logic [TAG_W-1:0]   sr_tag_q  [LATENCY];
  logic               sr_last_q [LATENCY];

  logic [TAG_W-1:0]   in_tag;

  always_comb begin
    grant = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = bus.req_valid;
    end
  end

  assign accept     = (state_q == S_IDLE) && (grant != 2'b00);
  assign winner     = grant[1];
  assign sel_lmul   = winner ? bus.req_lmul[3:2] : bus.req_lmul[1:0];
  assign sel_tag    = winner ? bus.req_tag[2*TAG_W-1:TAG_W] : bus.req_tag[TAG_W-1:0];
  assign last_issue = (state_q == S_ISSUE) && (idx_q == last_idx_q);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.req_ready     = 2'b00;
    bus.fma_issue     = 1'b0;
    bus.fma_group_idx = 3'd0;
    bus.fma_req_id    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = grant;
      end
      S_ISSUE: begin
        bus.fma_issue     = 1'b1;
        bus.fma_group_idx = idx_q;
        bus.fma_req_id    = id_q;
      end
      default: ;
    endcase
  end

  // Instruction context is captured at accept so later input changes cannot leak in.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      tag_q      <= '0;
      idx_q      <= 3'd0;
      last_idx_q <= 3'd0;
    end else if (accept) begin
      rr_q       <= ~winner;
      id_q       <= winner;
      tag_q      <= sel_tag;
      idx_q      <= 3'd0;
      last_idx_q <= 3'((4'd1 << sel_lmul) - 4'd1);
    end else if (state_q == S_ISSUE) begin
      idx_q <= idx_q + 3'd1;
    end
  end

  assign in_tag = bus.fma_issue ? tag_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_valid_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        sr_id_q[i]   <= 1'b0;
        sr_idx_q[i]  <= 3'd0;
        sr_tag_q[i]  <= '0;
        sr_last_q[i] <= 1'b0;
      end
    end else begin
      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
        sr_valid_q[i] <= sr_valid_q[i-1];
        sr_id_q[i]    <= sr_id_q[i-1];
        sr_idx_q[i]   <= sr_idx_q[i-1];
        sr_tag_q[i]   <= sr_tag_q[i-1];
        sr_last_q[i]  <= sr_last_q[i-1];
      end
      sr_valid_q[0] <= bus.fma_issue;
      sr_id_q[0]    <= bus.fma_req_id;
      sr_idx_q[0]   <= bus.fma_group_idx;
      sr_tag_q[0]   <= in_tag;
      sr_last_q[0]  <= last_issue;
    end
  end

  assign bus.wb_valid     = sr_valid_q[LATENCY-1];
  assign bus.wb_req_id    = sr_id_q[LATENCY-1];
  assign bus.wb_group_idx = sr_idx_q[LATENCY-1];
  assign bus.wb_tag       = sr_tag_q[LATENCY-1];
  assign bus.wb_last      = sr_last_q[LATENCY-1];
  assign bus.busy         = (state_q == S_ISSUE) || (sr_valid_q != '0);

endmodule

// File: tb/tb_vfma_issue_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic checked every cycle
// against a cycle-scheduled expectation model (issue/write-back calendars).
module tb_vfma_issue_sequencer;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned TW2   = 2 * TAG_W;

  logic clk = 1'b0;
  logic rst;
  bit   en = 1'b0;

  int checks = 0;
  int errors = 0;

  vfma_issue_sequencer_if #(.TAG_W(TAG_W)) bus ();

  vfma_issue_sequencer #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit             id;
    bit [2:0]       idx;
    bit [TAG_W-1:0] tag;
    bit             last;
  } op_t;

  // Expected activity keyed by cycle number.
  op_t exp_is [int];
  op_t exp_wb [int];
  int  cyc    = 0;
  int  m_free = 0;
  bit  m_rr   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Compare process and model update, once per cycle on the falling edge.
  logic [1:0] exp_g;
  bit         exp_busy;
  op_t        e;
  int         kq[$];
  always @(negedge clk) begin
    if (en) begin
      exp_g = 2'b00;
      if (cyc >= m_free) begin
        if (bus.req_valid == 2'b11) exp_g = m_rr ? 2'b10 : 2'b01;
        else                        exp_g = bus.req_valid;
      end
      chk("req_ready", int'(bus.req_ready), int'(exp_g));

      if (exp_is.exists(cyc)) begin
        e = exp_is[cyc];
        chk("fma_issue", int'(bus.fma_issue), 1);
        chk("fma_group_idx", int'(bus.fma_group_idx), int'(e.idx));
        chk("fma_req_id", int'(bus.fma_req_id), int'(e.id));
      end else begin
        chk("fma_issue", int'(bus.fma_issue), 0);
        chk("fma_group_idx", int'(bus.fma_group_idx), 0);
      end

      if (exp_wb.exists(cyc)) begin
        e = exp_wb[cyc];
        chk("wb_valid", int'(bus.wb_valid), 1);
        chk("wb_req_id", int'(bus.wb_req_id), int'(e.id));
        chk("wb_group_idx", int'(bus.wb_group_idx), int'(e.idx));
        chk("wb_tag", int'(bus.wb_tag), int'(e.tag));
        chk("wb_last", int'(bus.wb_last), int'(e.last));
      end else begin
        chk("wb_valid", int'(bus.wb_valid), 0);
        chk("wb_last", int'(bus.wb_last), 0);
        chk("wb_tag", int'(bus.wb_tag), 0);
      end

      exp_busy = exp_is.exists(cyc);
      for (int w = cyc; w < cyc + int'(LAT); w++) begin
        if (exp_wb.exists(w)) exp_busy = 1'b1;
      end
      chk("busy", int'(bus.busy), int'(exp_busy));

      if (rst) begin
        kq.delete();
        foreach (exp_is[k]) if (k > cyc) kq.push_back(k);
        foreach (kq[j]) exp_is.delete(kq[j]);
        kq.delete();
        foreach (exp_wb[k]) if (k > cyc) kq.push_back(k);
        foreach (kq[j]) exp_wb.delete(kq[j]);
        m_free = cyc + 1;
        m_rr   = 1'b0;
      end else if (exp_g != 2'b00) begin
        bit             w;
        bit [1:0]       lm;
        bit [TAG_W-1:0] tg;
        int             n;
        op_t            o;
        w  = exp_g[1];
        lm = w ? bus.req_lmul[3:2] : bus.req_lmul[1:0];
        tg = w ? bus.req_tag[TW2-1:TAG_W] : bus.req_tag[TAG_W-1:0];
        n  = 1 << lm;
        for (int k = 0; k < n; k++) begin
          o.id   = w;
          o.idx  = 3'(k);
          o.tag  = tg;
          o.last = (k == n - 1);
          exp_is[cyc + 1 + k]         = o;
          exp_wb[cyc + 1 + k + int'(LAT)] = o;
        end
        m_free = cyc + n + 1;
        m_rr   = ~w;
        $display("accept cyc=%0d req=%0d groups=%0d tag=%0h", cyc, w, n, tg);
      end
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_lmul  = 4'b0000;
    bus.req_tag   = '0;
    @(posedge clk);
    #1;
    en = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_wb_valid", int'(bus.wb_valid), 0);

    // Scenario 1: single LMUL=1 op from requester 0.
    next_cycle();
    bus.req_valid = 2'b01; bus.req_lmul = 4'b0000; bus.req_tag = TW2'(8'h05);
    @(negedge clk); chk("t1_ready", int'(bus.req_ready), 1);
    next_cycle(); bus.req_valid = 2'b00;
    @(negedge clk); chk("t1_issue", int'(bus.fma_issue), 1); chk("t1_idx", int'(bus.fma_group_idx), 0);
    next_cycle();
    next_cycle();
    @(negedge clk); chk("t1_wb", int'(bus.wb_valid), 1); chk("t1_tag", int'(bus.wb_tag), 5);
    chk("t1_last", int'(bus.wb_last), 1);
    next_cycle();
    @(negedge clk); chk("t1_busy", int'(bus.busy), 0);
    repeat (2) next_cycle();

    // Scenario 2/6: LMUL=8 from requester 1, inputs scrambled while issuing.
    bus.req_valid = 2'b10; bus.req_lmul = 4'b1100; bus.req_tag = TW2'(8'hA0);
    @(negedge clk); chk("t2_ready", int'(bus.req_ready), 2);
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      bus.req_valid = (k < 8) ? 2'b11 : 2'b00;
      bus.req_lmul  = 4'($urandom);
      bus.req_tag   = TW2'($urandom);
      @(negedge clk);
      if (k <= 8) begin
        chk("t2_idx", int'(bus.fma_group_idx), k - 1);
        chk("t2_ready_hold", int'(bus.req_ready), 0);
      end
      if (k >= 3) begin
        chk("t2_wb_tag", int'(bus.wb_tag), 10);
        chk("t2_wb_last", int'(bus.wb_last), (k == 10) ? 1 : 0);
      end
    end
    repeat (3) next_cycle();

    // Scenario 3: both requesters held, alternating grants.
    bus.req_lmul = 4'b0000; bus.req_tag = TW2'(8'h21);
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) next_cycle();
      bus.req_valid = (c < 7) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (c == 3 || c == 5 || c == 7 || c == 9)
        chk("t3_wb_id", int'(bus.wb_req_id), ((c - 3) / 2) % 2);
    end
    repeat (3) next_cycle();

    // Scenario 4: requester 0 held, LMUL=2, one bubble between instructions.
    bus.req_lmul = 4'b0001;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle();
      bus.req_valid = (c < 7) ? 2'b01 : 2'b00;
      @(negedge clk);
      chk("t4_issue", int'(bus.fma_issue), (c % 3 != 0) ? 1 : 0);
      if (c < 7) chk("t4_ready", int'(bus.req_ready), (c % 3 == 0) ? 1 : 0);
    end
    repeat (4) next_cycle();

    // Scenario 5: reset mid-instruction drops in-flight ops and restores rr.
    bus.req_valid = 2'b01; bus.req_lmul = 4'b0010; bus.req_tag = TW2'(8'h03);
    next_cycle(); bus.req_valid = 2'b00;
    next_cycle();
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    @(negedge clk); chk("t5_issue", int'(bus.fma_issue), 0); chk("t5_wb", int'(bus.wb_valid), 0);
    chk("t5_busy", int'(bus.busy), 0);
    next_cycle(); bus.req_valid = 2'b11;
    @(negedge clk); chk("t5_ready", int'(bus.req_ready), 1); chk("t5_wb2", int'(bus.wb_valid), 0);
    next_cycle(); bus.req_valid = 2'b00;
    repeat (12) next_cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      rst           = ($urandom_range(0, 63) == 0);
      bus.req_valid = 2'($urandom);
      bus.req_lmul  = 4'($urandom);
      bus.req_tag   = TW2'($urandom);
    end
    next_cycle();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    repeat (20) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
